// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: main control sequencer for the multicycle MIPS datapath.
// Inputs: clk, reset (sync, active-high), opcode/funct (instruction register fields),
//   zero (ALU zero flag), mem_ready (memory finishes the current access this cycle).
// Outputs: alu_control, alu_src_a, alu_src_b, pc_source, pc_write, iord, mem_read,
//   mem_write, ir_write, reg_dst, mem_to_reg, reg_write, illegal (one-cycle pulse),
//   state (debug).
// Build option: define MC_BNE_EN to dispatch bne (opcode 0x05) to BRANCH.
module mips_multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [3:0] alu_control,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic       pc_write,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       illegal,
    output logic [3:0] state
);
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] op_q, fn_q;
    logic       illegal_q, illegal_d;
    logic [3:0] r_alu;
    logic       r_ok;
    logic       br_take;

    // R-type ALU op comes from the funct latched in DECODE, not the live IR field.
    always_comb begin
        r_ok  = 1'b1;
        r_alu = ALU_ADD;
        case (fn_q)
            6'h20:   r_alu = ALU_ADD;
            6'h22:   r_alu = ALU_SUB;
            6'h24:   r_alu = ALU_AND;
            6'h25:   r_alu = ALU_OR;
            6'h27:   r_alu = ALU_NOR;
            6'h2A:   r_alu = ALU_SLT;
            6'h00:   r_alu = ALU_SLL;
            default: r_ok  = 1'b0;
        endcase
    end

`ifdef MC_BNE_EN
    assign br_take = (op_q == 6'h05) ? ~zero : zero;
`else
    assign br_take = zero;
`endif

    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
        case (state_q)
            S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_R:         state_d = S_R_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
`ifdef MC_BNE_EN
                    6'h05:        state_d = S_BRANCH;
`endif
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EXEC;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR:  state_d = (op_q == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
            S_R_EXEC: begin
                state_d   = r_ok ? S_R_WB : S_FETCH;
                illegal_d = ~r_ok;
            end
            S_ADDI_EXEC: state_d = S_ADDI_WB;
            default:     state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            op_q      <= 6'h00;
            fn_q      <= 6'h00;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            if (state_q == S_DECODE) begin
                op_q <= opcode;
                fn_q <= funct;
            end
        end
    end

    // FETCH write enables follow mem_ready so IR/PC load only on the completing cycle.
    always_comb begin
        alu_control = ALU_ADD;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        pc_source   = 2'b00;
        pc_write    = 1'b0;
        iord        = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE:    alu_src_b = 2'b11;
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEM_READ: begin
                iord     = 1'b1;
                mem_read = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_R_EXEC: begin
                alu_src_a   = 1'b1;
                alu_control = r_alu;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = ALU_SUB;
                pc_source   = 2'b01;
                pc_write    = br_take;
            end
            S_JUMP: begin
                pc_source = 2'b10;
                pc_write  = 1'b1;
            end
            S_ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_ADDI_WB:   reg_write = 1'b1;
            default:     alu_control = ALU_ADD;
        endcase
        if (reset) begin
            alu_control = ALU_ADD;
            pc_write    = 1'b0;
            mem_read    = 1'b0;
            mem_write   = 1'b0;
            ir_write    = 1'b0;
            reg_write   = 1'b0;
        end
    end

    assign illegal = illegal_q & ~reset;
    assign state   = state_q;
endmodule
